// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the boot-loading instruction memory.
package imem_boot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } boot_state_t;

  localparam logic [31:0] INSTR_FILL     = 32'h0;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream load channel: valid/ready handshake, one program byte per beat.
interface imem_boot_loader_if;

  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;

  modport master (output load_valid, output load_data, output load_last, input load_ready);
  modport slave  (input load_valid, input load_data, input load_last, output load_ready);

endinterface

// File: rtl/imem_ram.sv
// DEPTH_WORDS x 32 instruction store: synchronous write, asynchronous read, no reset.
module imem_ram #(
  parameter  int DEPTH_WORDS = 64,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Packs a little-endian byte stream into instruction memory, then gates the core via start.
// Write lands on the 4th/last handshake edge; Instr is a zero-latency read; load_ready only in LOAD.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 boot_req,
  imem_boot_loader_if.slave    load,
  input  logic [31:0]          PC,
  output logic [31:0]          Instr,
  output logic                 start,
  output logic [ADDR_W:0]      words_loaded,
  output logic                 overflow
);

  boot_state_t state, state_nxt;
  logic [1:0]  idx;
  logic [31:0] asm_q;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdy;
  logic        restart;
  logic        hs;
  logic        word_done;
  logic        full;
  logic        we;
  logic        in_range;
  logic        unused_pc_lsb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (boot_req) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      LOAD: begin
        rdy = 1'b1;
        if (load.load_valid && load.load_last) state_nxt = RUN;
      end
      RUN: begin
        if (boot_req) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load.load_ready = rdy;
  assign hs        = load.load_valid & rdy;
  assign word_done = hs & ((idx == 2'(BYTES_PER_WORD - 1)) | load.load_last);
  // Counter saturates at DEPTH_WORDS, so its top bit alone means "memory full".
  assign full      = words_loaded[ADDR_W];
  assign we        = word_done & ~full;

  always_comb begin
    wdata = asm_q;
    wdata[{idx, 3'b000} +: 8] = load.load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      asm_q        <= '0;
      words_loaded <= '0;
      overflow     <= 1'b0;
      start        <= 1'b0;
    end else begin
      start <= (state_nxt == RUN);
      if (restart) begin
        idx          <= '0;
        asm_q        <= '0;
        words_loaded <= '0;
        overflow     <= 1'b0;
      end else if (hs) begin
        if (word_done) begin
          // Clearing here is what zero-fills the upper lanes of the next partial word.
          idx   <= '0;
          asm_q <= '0;
          if (full) overflow     <= 1'b1;
          else      words_loaded <= words_loaded + 1'b1;
        end else begin
          idx   <= idx + 1'b1;
          asm_q <= wdata;
        end
      end
    end
  end

  imem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (words_loaded[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (PC[ADDR_W+1:2]),
    .rdata (rdata)
  );

  assign in_range      = (PC[31:ADDR_W+2] == '0);
  assign Instr         = ((state == RUN) && in_range) ? rdata : INSTR_FILL;
  assign unused_pc_lsb = ^PC[1:0];

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench: a 64-word loader and a 4-word loader share the byte stream, each booted separately.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_a, boot_b;
  logic        lv, ll;
  logic [7:0]  ld;
  logic [31:0] pc;
  logic [31:0] instr_a, instr_b;
  logic        start_a, start_b;
  logic [6:0]  wl_a;
  logic [2:0]  wl_b;
  logic        ovf_a, ovf_b;

  int checks   = 0;
  int failures = 0;

  imem_boot_loader_if ifa ();
  imem_boot_loader_if ifb ();

  assign ifa.load_valid = lv;
  assign ifa.load_data  = ld;
  assign ifa.load_last  = ll;
  assign ifb.load_valid = lv;
  assign ifb.load_data  = ld;
  assign ifb.load_last  = ll;

  imem_boot_loader #(.DEPTH_WORDS(64)) dut_a (
    .clk(clk), .reset(rst), .boot_req(boot_a), .load(ifa), .PC(pc),
    .Instr(instr_a), .start(start_a), .words_loaded(wl_a), .overflow(ovf_a)
  );

  imem_boot_loader #(.DEPTH_WORDS(4)) dut_b (
    .clk(clk), .reset(rst), .boot_req(boot_b), .load(ifb), .PC(pc),
    .Instr(instr_b), .start(start_b), .words_loaded(wl_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          phase;
    bit          sel;
    logic [31:0] pc;
    logic [31:0] instr;
    string       name;
  } rd_vec_t;

  rd_vec_t vec [32];
  int      nv = 0;

  task automatic addv(input int ph, input bit s, input logic [31:0] p, input logic [31:0] e,
                      input string n);
    vec[nv].phase = ph;
    vec[nv].sel   = s;
    vec[nv].pc    = p;
    vec[nv].instr = e;
    vec[nv].name  = n;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_reads(input int ph);
    for (int i = 0; i < nv; i++) begin
      if (vec[i].phase == ph) begin
        @(negedge clk);
        pc = vec[i].pc;
        #1;
        chk(vec[i].name, vec[i].sel ? instr_b : instr_a, vec[i].instr);
      end
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send(input logic [7:0] b, input bit last, input bit sel, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 1) == 1) begin
      lv = 1'b0;
      @(negedge clk);
    end
    lv = 1'b1;
    ld = b;
    ll = last;
    n  = 0;
    while (!(sel ? ifb.load_ready : ifa.load_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("handshake_timeout", 32'(n), 32'd0);
    @(negedge clk);
    if (last) begin
      lv = 1'b0;
      ll = 1'b0;
    end
  endtask

  task automatic boot(input bit sel);
    if (sel) boot_b = 1'b1;
    else     boot_a = 1'b1;
    @(negedge clk);
    boot_a = 1'b0;
    boot_b = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addv(1, 1'b0, 32'h0000_0000, 32'h0403_0201, "p1_pc0");
    addv(1, 1'b0, 32'h0000_0004, 32'h0807_0605, "p1_pc4");
    addv(1, 1'b0, 32'h0000_0001, 32'h0403_0201, "p1_pc1_lsb_ignored");
    addv(1, 1'b0, 32'h0000_0007, 32'h0807_0605, "p1_pc7_lsb_ignored");
    addv(1, 1'b0, 32'h0000_0100, 32'h0000_0000, "p1_pc_out_of_range");
    addv(1, 1'b0, 32'h8000_0000, 32'h0000_0000, "p1_pc_msb_out_of_range");
    addv(2, 1'b0, 32'h0000_0000, 32'hDDCC_BBAA, "p2_pc0_reload");
    addv(2, 1'b0, 32'h0000_0004, 32'h0000_00EE, "p2_pc4_zero_fill");
    addv(2, 1'b0, 32'h0000_0003, 32'hDDCC_BBAA, "p2_pc3");
    addv(3, 1'b1, 32'h0000_0000, 32'h1312_1110, "p3_b_word0");
    addv(3, 1'b1, 32'h0000_0008, 32'h1B1A_1918, "p3_b_word2");
    addv(3, 1'b1, 32'h0000_000C, 32'h1F1E_1D1C, "p3_b_word3");
    addv(3, 1'b1, 32'h0000_0010, 32'h0000_0000, "p3_b_pc16_range");
    addv(3, 1'b0, 32'h0000_0000, 32'hDDCC_BBAA, "p3_a_untouched");
    addv(4, 1'b0, 32'h0000_0000, 32'h6463_6261, "p4_pc0_after_reset");
    addv(4, 1'b0, 32'h0000_0004, 32'h0000_00EE, "p4_pc4_mem_kept");
    addv(5, 1'b0, 32'h0000_0000, 32'h8382_8180, "p5_word0");
    addv(5, 1'b0, 32'h0000_0004, 32'h8786_8584, "p5_word1");
    addv(5, 1'b0, 32'h0000_0008, 32'h8B8A_8988, "p5_word2");
    addv(5, 1'b0, 32'h0000_000C, 32'h8F8E_8D8C, "p5_word3");

    rst = 1'b1; boot_a = 1'b0; boot_b = 1'b0;
    lv = 1'b0; ll = 1'b0; ld = 8'h00; pc = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_start", 32'(start_a), 32'd0);
    chk("rst_ready", 32'(ifa.load_ready), 32'd0);
    chk("rst_overflow", 32'(ovf_a), 32'd0);
    chk("rst_words", 32'(wl_a), 32'd0);
    chk("rst_instr", instr_a, 32'h0);

    // 8-byte back-to-back load, start timing around the last handshake
    @(negedge clk);
    boot(1'b0);
    for (int i = 1; i <= 7; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
    chk("p1_start_before_last", 32'(start_a), 32'd0);
    chk("p1_ready_before_last", 32'(ifa.load_ready), 32'd1);
    send(8'h08, 1'b1, 1'b0, 1'b0);
    chk("p1_start_rise", 32'(start_a), 32'd1);
    chk("p1_ready_fall", 32'(ifa.load_ready), 32'd0);
    chk("p1_words", 32'(wl_a), 32'd2);
    run_reads(1);

    // restart from RUN, then a 5-byte image with a partial last word
    @(negedge clk);
    pc = 32'h0;
    boot(1'b0);
    #1;
    chk("p2_start_fall", 32'(start_a), 32'd0);
    chk("p2_ready_rise", 32'(ifa.load_ready), 32'd1);
    chk("p2_instr_gated", instr_a, 32'h0);
    chk("p2_words_cleared", 32'(wl_a), 32'd0);
    @(negedge clk);
    send(8'hAA, 1'b0, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0, 1'b0);
    send(8'hDD, 1'b0, 1'b0, 1'b0);
    send(8'hEE, 1'b1, 1'b0, 1'b0);
    chk("p2_words", 32'(wl_a), 32'd2);
    run_reads(2);

    // 20 bytes into the 4-word instance
    @(negedge clk);
    boot(1'b1);
    for (int i = 0; i < 20; i++) send(8'(8'h10 + i), (i == 19), 1'b1, 1'b0);
    chk("p3_b_overflow", 32'(ovf_b), 32'd1);
    chk("p3_b_words_sat", 32'(wl_b), 32'd4);
    chk("p3_b_start", 32'(start_b), 32'd1);
    chk("p3_a_overflow", 32'(ovf_a), 32'd0);
    run_reads(3);

    // reset in the middle of a load
    @(negedge clk);
    boot(1'b0);
    for (int i = 0; i < 6; i++) send(8'(8'h55 + i), 1'b0, 1'b0, 1'b0);
    lv  = 1'b0;
    rst = 1'b1;
    #1;
    chk("p4_rst_start", 32'(start_a), 32'd0);
    chk("p4_rst_ready", 32'(ifa.load_ready), 32'd0);
    chk("p4_rst_words", 32'(wl_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("p4_idle_start", 32'(start_a), 32'd0);
    boot(1'b0);
    for (int i = 0; i < 4; i++) send(8'(8'h61 + i), (i == 3), 1'b0, 1'b0);
    chk("p4_words", 32'(wl_a), 32'd1);
    chk("p4_start", 32'(start_a), 32'd1);
    run_reads(4);

    // 16 bytes with random valid gaps and a boot_req pulse mid-load
    @(negedge clk);
    boot(1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) boot_a = 1'b1;
      send(8'(8'h80 + i), (i == 15), 1'b0, 1'b1);
      boot_a = 1'b0;
    end
    chk("p5_words", 32'(wl_a), 32'd4);
    chk("p5_overflow", 32'(ovf_a), 32'd0);
    run_reads(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
